// File: rtl/uart_rx_block.sv
// 8N1 UART receiver that packs sixteen received bytes into one 128-bit block
// and hands it to the AES loader over a valid/ready handshake.
module uart_rx_block #(
    parameter int CLKS_PER_BIT    = 87,
    parameter int BYTES_PER_BLOCK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         uart_rx,
    output logic [127:0] o_block,
    output logic         o_block_valid,
    input  logic         i_block_ready,
    output logic         o_frame_err,
    output logic         o_overrun
);

    localparam logic [15:0] HALF_CNT  = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           rx_meta;
    logic           rx_s;
    logic [15:0]    baud_cnt;
    logic [2:0]     bit_cnt;
    logic [3:0]     byte_idx;
    logic [7:0]     shift_reg;
    logic [127:0]   asm_reg;

    logic           cnt_clr;
    logic           bit_sample;
    logic           byte_ok;
    logic           stop_bad;
    logic [127:0]   asm_next;
    logic           block_done;
    logic           block_load;

    assign asm_next   = {asm_reg[119:0], shift_reg};
    assign block_done = byte_ok && (byte_idx == LAST_BYTE);
    assign block_load = block_done && (!o_block_valid || i_block_ready);

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        bit_sample = 1'b0;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == HALF_CNT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    cnt_clr    = 1'b1;
                    bit_sample = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        byte_ok   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A framing error abandons the partial block so the next one starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            asm_reg   <= '0;
        end else begin
            baud_cnt <= cnt_clr ? 16'd0 : baud_cnt + 16'd1;
            if (state == S_IDLE) begin
                bit_cnt <= '0;
            end else if (bit_sample) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (bit_sample) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
            end
            if (stop_bad) begin
                byte_idx <= '0;
            end else if (byte_ok) begin
                byte_idx <= (byte_idx == LAST_BYTE) ? 4'd0 : byte_idx + 4'd1;
            end
            if (byte_ok) begin
                asm_reg <= asm_next;
            end
        end
    end

    // A block arriving into a full, undrained slot is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_block       <= '0;
            o_block_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            if (block_load) begin
                o_block       <= asm_next;
                o_block_valid <= 1'b1;
            end else if (o_block_valid && i_block_ready) begin
                o_block_valid <= 1'b0;
            end
            o_frame_err <= stop_bad;
            o_overrun   <= block_done && !block_load;
        end
    end

endmodule

// File: tb/tb_uart_rx_block.sv
// Randomized bench for uart_rx_block: a byte-level reference model predicts
// blocks into a queue and a monitor compares every handshake transfer.
module tb_uart_rx_block;

    localparam int CPB    = 24;
    localparam int HALF   = (CPB - 1) / 2;
    localparam int NBYTES = 16;
    localparam logic [127:0] NOMINAL = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_rx = 1'b1;
    logic         i_block_ready = 1'b0;
    logic [127:0] o_block;
    logic         o_block_valid;
    logic         o_frame_err;
    logic         o_overrun;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   cur_bytes[$];
    int           exp_frame_err = 0;
    int           exp_overrun = 0;
    int           seen_frame_err = 0;
    int           seen_overrun = 0;
    bit           slot_busy = 1'b0;
    logic [127:0] blk;
    logic [7:0]   part_byte;

    uart_rx_block #(
        .CLKS_PER_BIT    (CPB),
        .BYTES_PER_BLOCK (NBYTES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .o_block       (o_block),
        .o_block_valid (o_block_valid),
        .i_block_ready (i_block_ready),
        .o_frame_err   (o_frame_err),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // First byte of a block lands in the top byte lane.
    function automatic void model_byte(input logic [7:0] b);
        logic [127:0] m;
        cur_bytes.push_back(b);
        if (cur_bytes.size() == NBYTES) begin
            m = '0;
            for (int i = 0; i < NBYTES; i++) begin
                m[127 - 8*i -: 8] = cur_bytes[i];
            end
            cur_bytes.delete();
            if (slot_busy) begin
                exp_overrun++;
            end else begin
                exp_q.push_back(m);
            end
        end
    endfunction

    // Drives one 8N1 frame on negedges; optionally pulses ready for the single
    // cycle in which the receiver samples this frame's stop bit.
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_val,
                                  input bit pulse_ready, input int gap);
        logic [9:0] frame;
        if (stop_val) begin
            model_byte(b);
        end else begin
            cur_bytes.delete();
            exp_frame_err++;
        end
        frame = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            for (int c = 0; c < CPB; c++) begin
                if (pulse_ready && i == 9) begin
                    if (c == HALF + 3) begin
                        i_block_ready = 1'b1;
                    end else if (c == HALF + 4) begin
                        i_block_ready = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_random_block(input int max_gap, input bit pulse_last);
        for (int i = 0; i < NBYTES; i++) begin
            apply_stimulus(8'($urandom), 1'b1, pulse_last && (i == NBYTES - 1),
                           (i == NBYTES - 1) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic check_phase(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20 * CPB) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        check_count({name, "_pending_blocks"}, exp_q.size(), 0);
        check_count({name, "_frame_err_cycles"}, seen_frame_err, exp_frame_err);
        check_count({name, "_overrun_cycles"}, seen_overrun, exp_overrun);
    endtask

    // Monitor: every valid&&ready cycle is one transfer and must match the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (o_frame_err === 1'b1) seen_frame_err++;
                if (o_overrun === 1'b1) seen_overrun++;
                if (o_block_valid === 1'b1 && i_block_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL unexpected_block: got %h expected none", o_block);
                    end else begin
                        check_output("block", o_block, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        n_err++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_block", o_block, 128'd0);
        check_output("reset_valid", 128'(o_block_valid), 128'd0);
        check_output("reset_frame_err", 128'(o_frame_err), 128'd0);
        check_output("reset_overrun", 128'(o_overrun), 128'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] nominal block");
        i_block_ready = 1'b1;
        blk = NOMINAL;
        for (int i = 0; i < NBYTES; i++) begin
            apply_stimulus(blk[127 - 8*i -: 8], 1'b1, 1'b0, 0);
        end
        check_phase("nominal");

        $display("[TB] false start");
        uart_rx = 1'b0;
        repeat ($urandom_range(1, HALF - 1)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_output("false_start_valid", 128'(o_block_valid), 128'd0);
        send_random_block(3, 1'b0);
        check_phase("false_start");

        $display("[TB] frame error");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'($urandom), 1'b1, 1'b0, 0);
        end
        apply_stimulus(8'($urandom), 1'b0, 1'b0, CPB);
        for (int i = 0; i < NBYTES; i++) begin
            apply_stimulus(8'(i), 1'b1, 1'b0, 0);
        end
        check_phase("frame_err");

        $display("[TB] backpressure and overrun");
        i_block_ready = 1'b0;
        for (int i = 0; i < NBYTES; i++) apply_stimulus(8'h11, 1'b1, 1'b0, 0);
        slot_busy = 1'b1;
        for (int i = 0; i < NBYTES; i++) apply_stimulus(8'h22, 1'b1, 1'b0, 0);
        repeat (5) @(negedge clk);
        check_output("held_valid", 128'(o_block_valid), 128'd1);
        check_output("held_block", o_block, {16{8'h11}});
        slot_busy = 1'b0;
        i_block_ready = 1'b1;
        @(negedge clk);
        check_output("drained_valid", 128'(o_block_valid), 128'd0);
        check_output("drained_block", o_block, {16{8'h11}});
        check_phase("overrun");

        $display("[TB] simultaneous drain and load");
        i_block_ready = 1'b0;
        send_random_block(2, 1'b0);
        send_random_block(2, 1'b1);
        repeat (3) @(negedge clk);
        check_output("swap_valid", 128'(o_block_valid), 128'd1);
        check_count("swap_queue_depth", exp_q.size(), 1);
        i_block_ready = 1'b1;
        check_phase("drain_load");

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(8'($urandom), 1'b1, 1'b0, 0);
        end
        part_byte = 8'($urandom);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            uart_rx = part_byte[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = part_byte[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        cur_bytes.delete();
        #1;
        check_output("midreset_block", o_block, 128'd0);
        check_output("midreset_valid", 128'(o_block_valid), 128'd0);
        check_output("midreset_frame_err", 128'(o_frame_err), 128'd0);
        check_output("midreset_overrun", 128'(o_overrun), 128'd0);
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_random_block(1, 1'b0);
        check_phase("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
